// File: rtl/n101_uart_pkg.sv
// Shared constants for the n101 UART engines: state encoding and frame geometry.
package n101_uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_SYNC_DEFAULT = 2;

  // True when the bit just shifted in is the final data bit of the frame.
  function automatic logic is_last_bit(input logic [2:0] idx);
    return idx == 3'(UART_DATA_BITS - 1);
  endfunction

endpackage

// File: rtl/n101_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit with a configurable reset value.
module n101_sync_bit
  import n101_uart_pkg::*;
#(
  parameter int   STAGES    = UART_SYNC_DEFAULT,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/n101_uart_rx.sv
// 8N1 UART receive engine with a programmable bit period and a one-entry valid/ready holding register.
module n101_uart_rx
  import n101_uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = UART_SYNC_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_rxd,
  input  logic [DIV_W-1:0] io_div,
  input  logic             io_enable,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [7:0]       io_out_bits,
  output logic             io_err_frame,
  output logic             io_err_overrun,
  output logic             io_busy
);

  logic             rxd_s;
  logic             rxdPrev_q;
  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shReg_q, shReg_d;
  logic             valid_q, valid_d;
  logic [7:0]       outBits_q, outBits_d;
  logic             errFrame_q, errFrame_d;
  logic             errOverrun_q, errOverrun_d;
  logic             startEdge;
  logic             cntZero;
  logic             dequeue;

  n101_sync_bit #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d_i  (io_rxd),
    .q_o  (rxd_s)
  );

  // A falling edge is required, so a line parked low (break) never retriggers.
  assign startEdge = io_enable & rxdPrev_q & ~rxd_s;
  assign cntZero   = (cnt_q == '0);
  assign dequeue   = valid_q & io_out_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    bitIdx_d     = bitIdx_q;
    shReg_d      = shReg_q;
    valid_d      = valid_q & ~dequeue;
    outBits_d    = outBits_q;
    errFrame_d   = 1'b0;
    errOverrun_d = 1'b0;

    if (!io_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (startEdge) begin
            div_d   = io_div;
            cnt_d   = io_div >> 1;
            state_d = ST_START;
          end
        end
        ST_START: begin
          if (cntZero) begin
            if (rxd_s) begin
              state_d = ST_IDLE;
            end else begin
              cnt_d    = div_q;
              bitIdx_d = 3'd0;
              state_d  = ST_DATA;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_DATA: begin
          if (cntZero) begin
            shReg_d  = {rxd_s, shReg_q[7:1]};
            cnt_d    = div_q;
            bitIdx_d = bitIdx_q + 3'd1;
            if (is_last_bit(bitIdx_q)) begin
              state_d = ST_STOP;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_STOP: begin
          if (cntZero) begin
            state_d = ST_IDLE;
            // A slot frees up if the consumer is draining the register this very cycle.
            if (rxd_s) begin
              if (!valid_q || io_out_ready) begin
                valid_d   = 1'b1;
                outBits_d = shReg_q;
              end else begin
                errOverrun_d = 1'b1;
              end
            end else begin
              errFrame_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxdPrev_q    <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      div_q        <= '0;
      bitIdx_q     <= 3'd0;
      shReg_q      <= 8'd0;
      valid_q      <= 1'b0;
      outBits_q    <= 8'd0;
      errFrame_q   <= 1'b0;
      errOverrun_q <= 1'b0;
    end else begin
      rxdPrev_q    <= rxd_s;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      bitIdx_q     <= bitIdx_d;
      shReg_q      <= shReg_d;
      valid_q      <= valid_d;
      outBits_q    <= outBits_d;
      errFrame_q   <= errFrame_d;
      errOverrun_q <= errOverrun_d;
    end
  end

  assign io_out_valid   = valid_q;
  assign io_out_bits    = outBits_q;
  assign io_err_frame   = errFrame_q;
  assign io_err_overrun = errOverrun_q;
  assign io_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_n101_uart_rx.sv
// Bench for n101_uart_rx: directed frames with hand-computed timing plus randomized traffic,
// all checked every cycle against a timeline model built from the sample-point arithmetic.
module tb_n101_uart_rx;

  localparam int DIV_W = 16;
  localparam int MAXC  = 100000;
  localparam int LIMIT = 60000;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             io_rxd = 1'b1;
  logic [DIV_W-1:0] io_div = 16'd15;
  logic             io_enable = 1'b1;
  logic             io_out_ready = 1'b0;
  logic             io_out_valid;
  logic [7:0]       io_out_bits;
  logic             io_err_frame;
  logic             io_err_overrun;
  logic             io_busy;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit randReady = 1'b0;

  // Model state: line history as seen by the DUT, plus the frame currently in flight.
  bit         hist [0:MAXC-1];
  bit         mActive = 1'b0;
  int         mDiv = 0, mStartS = 0, mStopS = 0;
  logic       mValid = 1'b0, mFe = 1'b0, mOv = 1'b0, mBusy = 1'b0;
  logic [7:0] mBits = 8'd0;

  int   riseCnt = 0, lastRise = -1, feCnt = 0, lastFe = -1, ovCnt = 0, lastOv = -1;
  int   lastDeq = -1;
  logic prevValid = 1'b0;

  n101_uart_rx #(.DIV_W(DIV_W), .SYNC_STAGES(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_rxd        (io_rxd),
    .io_div        (io_div),
    .io_enable     (io_enable),
    .io_out_valid  (io_out_valid),
    .io_out_ready  (io_out_ready),
    .io_out_bits   (io_out_bits),
    .io_err_frame  (io_err_frame),
    .io_err_overrun(io_err_overrun),
    .io_busy       (io_busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  // The serial value the DUT's synchronizer presents in cycle n (two flops behind the pin).
  function automatic bit lineS(input int n);
    return (n < 2) ? 1'b1 : hist[n-2];
  endfunction

  task automatic modelStep(input int n);
    logic       nValid, nFe, nOv;
    logic [7:0] nBits, b;
    nValid = mValid && !io_out_ready;
    nBits  = mBits;
    nFe    = 1'b0;
    nOv    = 1'b0;
    b      = 8'd0;
    if (mActive) begin
      if (!io_enable) begin
        mActive = 1'b0;
      end else if (n == mStartS && lineS(n)) begin
        mActive = 1'b0;
      end else if (n == mStopS) begin
        mActive = 1'b0;
        if (lineS(n)) begin
          for (int k = 0; k < 8; k++) b[k] = lineS(mStartS + (k + 1) * (mDiv + 1));
          if (!mValid || io_out_ready) begin
            nValid = 1'b1;
            nBits  = b;
          end else begin
            nOv = 1'b1;
          end
        end else begin
          nFe = 1'b1;
        end
      end
    end else if (io_enable && !lineS(n) && lineS(n - 1)) begin
      mActive = 1'b1;
      mDiv    = int'(io_div);
      mStartS = n + mDiv / 2 + 1;
      mStopS  = mStartS + 9 * (mDiv + 1);
    end
    mValid = nValid;
    mBits  = nBits;
    mFe    = nFe;
    mOv    = nOv;
    mBusy  = mActive;
  endtask

  initial begin : compare
    forever begin
      @(negedge clock);
      if (reset) begin
        hist[cyc] = 1'b1;
        mActive = 1'b0;
        mValid = 1'b0;
        mBits = 8'd0;
        mFe = 1'b0;
        mOv = 1'b0;
        mBusy = 1'b0;
      end else begin
        hist[cyc] = io_rxd;
      end
      checkOutput("valid", int'(io_out_valid), int'(mValid));
      checkOutput("bits", int'(io_out_bits), int'(mBits));
      checkOutput("err_frame", int'(io_err_frame), int'(mFe));
      checkOutput("err_overrun", int'(io_err_overrun), int'(mOv));
      checkOutput("busy", int'(io_busy), int'(mBusy));
      if (io_out_valid && !prevValid) begin riseCnt++; lastRise = cyc; end
      prevValid = io_out_valid;
      if (io_err_frame) begin feCnt++; lastFe = cyc; end
      if (io_err_overrun) begin ovCnt++; lastOv = cyc; end
      if (!reset && io_out_valid && io_out_ready) lastDeq = int'(io_out_bits);
      if (!reset) modelStep(cyc);
    end
  end

  initial begin : watchdog
    wait (cyc >= LIMIT);
    $display("[TB] FAIL watchdog: reached cycle %0d, limit %0d", cyc, LIMIT);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic driveCycle(input logic v);
    @(posedge clock);
    #1;
    io_rxd = v;
    if (randReady) io_out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) driveCycle(1'b1);
  endtask

  task automatic gotoCycle(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drives one 8N1 frame with each bit held div+1 clocks; c is the first start-bit cycle.
  task automatic applyStimulus(input logic [7:0] b, input logic stopV, input int d, output int c);
    logic v;
    c = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      v = (i == 0) ? 1'b0 : (i == 9) ? stopV : b[i-1];
      for (int j = 0; j <= d; j++) driveCycle(v);
    end
  endtask

  initial begin : stimulus
    int c1, c2, cx, r0, f0, o0, d;
    logic [7:0] b;
    logic good;

    repeat (3) driveCycle(1'b1);
    checkOutput("rst_valid", int'(io_out_valid), 0);
    checkOutput("rst_bits", int'(io_out_bits), 0);
    checkOutput("rst_busy", int'(io_busy), 0);
    reset = 1'b0;
    io_out_ready = 1'b1;
    idle(5);

    // 0xA5 at div=15: valid at T0+153 where T0 = c+2.
    r0 = riseCnt; f0 = feCnt; o0 = ovCnt;
    applyStimulus(8'hA5, 1'b1, 15, c1);
    idle(4);
    checkOutput("a5_rise_cycle", lastRise, c1 + 155);
    checkOutput("a5_rises", riseCnt - r0, 1);
    checkOutput("a5_byte", lastDeq, 32'hA5);
    checkOutput("a5_errs", (feCnt - f0) + (ovCnt - o0), 0);

    // False start: 4 low clocks; start sample at T0+8 aborts.
    r0 = riseCnt; f0 = feCnt; o0 = ovCnt;
    c1 = cyc + 1;
    repeat (4) driveCycle(1'b0);
    driveCycle(1'b1);
    gotoCycle(c1 + 10);
    checkOutput("fs_busy_high", int'(io_busy), 1);
    gotoCycle(c1 + 11);
    checkOutput("fs_busy_low", int'(io_busy), 0);
    idle(4);
    checkOutput("fs_no_events", (riseCnt - r0) + (feCnt - f0) + (ovCnt - o0), 0);

    // 0x3C with a bad stop bit, then the line parked low.
    r0 = riseCnt; f0 = feCnt;
    applyStimulus(8'h3C, 1'b0, 15, c1);
    repeat (100) driveCycle(1'b0);
    checkOutput("fe_count", feCnt - f0, 1);
    checkOutput("fe_cycle", lastFe, c1 + 155);
    checkOutput("fe_no_valid", riseCnt - r0, 0);
    checkOutput("fe_break_idle", int'(io_busy), 0);
    idle(10);

    // Overrun: ready low across two back-to-back frames.
    io_out_ready = 1'b0;
    o0 = ovCnt;
    applyStimulus(8'h11, 1'b1, 15, c1);
    applyStimulus(8'h22, 1'b1, 15, c2);
    idle(4);
    checkOutput("ovr_count", ovCnt - o0, 1);
    checkOutput("ovr_cycle", lastOv, c2 + 155);
    checkOutput("ovr_held_valid", int'(io_out_valid), 1);
    checkOutput("ovr_held_bits", int'(io_out_bits), 32'h11);
    io_out_ready = 1'b1;
    driveCycle(1'b1);
    io_out_ready = 1'b0;
    checkOutput("ovr_deq_byte", lastDeq, 32'h11);
    checkOutput("ovr_valid_clear", int'(io_out_valid), 0);
    idle(4);

    // Dequeue and load in the same cycle as the second stop sample.
    o0 = ovCnt;
    c1 = cyc + 1;
    fork
      begin
        applyStimulus(8'h11, 1'b1, 15, cx);
        applyStimulus(8'h22, 1'b1, 15, c2);
      end
      begin
        gotoCycle(c1 + 314);
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;
      end
    join
    idle(4);
    checkOutput("swap_no_overrun", ovCnt - o0, 0);
    checkOutput("swap_valid", int'(io_out_valid), 1);
    checkOutput("swap_bits", int'(io_out_bits), 32'h22);
    checkOutput("swap_deq_byte", lastDeq, 32'h11);
    io_out_ready = 1'b1;
    idle(5);

    // Reset during data bit 4 of 0xFF, then 0x5A with io_div changed mid-frame.
    r0 = riseCnt;
    c1 = cyc + 1;
    fork
      applyStimulus(8'hFF, 1'b1, 15, cx);
      begin
        gotoCycle(c1 + 82);
        checkOutput("mid_busy_before", int'(io_busy), 1);
        reset = 1'b1;
        #1;
        checkOutput("mid_busy_reset", int'(io_busy), 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
      end
    join
    idle(5);
    checkOutput("mid_no_output", riseCnt - r0, 0);
    c1 = cyc + 1;
    fork
      applyStimulus(8'h5A, 1'b1, 15, c2);
      begin
        gotoCycle(c1 + 50);
        io_div = 16'd7;
      end
    join
    idle(4);
    checkOutput("div_rise_cycle", lastRise, c2 + 155);
    checkOutput("div_byte", lastDeq, 32'h5A);
    io_div = 16'd15;
    idle(5);

    // Randomized traffic: divisors, bytes, stop bits, glitches, enable drops, ready toggling.
    randReady = 1'b1;
    for (int f = 0; f < 24; f++) begin
      d = $urandom_range(3, 12);
      io_div = 16'(d);
      b = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 7))
        0: begin
          repeat ($urandom_range(1, 3)) driveCycle(1'b0);
          idle(d + 3);
        end
        1: begin
          fork
            applyStimulus(b, good, d, cx);
            begin
              repeat ($urandom_range(5, 9 * (d + 1))) @(posedge clock);
              #1;
              io_enable = 1'b0;
              @(posedge clock);
              #1;
              io_enable = 1'b1;
            end
          join
        end
        default: applyStimulus(b, good, d, cx);
      endcase
      idle($urandom_range(1, 6));
    end
    randReady = 1'b0;
    io_out_ready = 1'b1;
    idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/n101_uart_rx.md
Name: n101_uart_rx

Overview:
- UART receive engine for the n101 peripheral subsystem.
- Consumes the serial line produced by the UART pin mux (`io_uart_rxd`, sourced from the RXD pad).
- Recovers 8N1 frames, LSB first, at a programmable bit period.
- Hands each byte to the UART register/FIFO logic over a one-entry valid/ready holding register, with framing and overrun error strobes.

Parameters:
- DIV_W, 16: width of the bit-period divisor input.
- SYNC_STAGES, 2: number of synchronizer flops on the serial input; minimum 2.

Ports:
- clock  input  1  single clock for all state.
- reset  input  1  asynchronous, active-high reset.
- io_rxd  input  1  asynchronous serial line, idle high.
- io_div  input  DIV_W  bit period minus one, in clocks; legal range 3..2^DIV_W-1.
- io_enable  input  1  receiver enable; when 0, state is forced to IDLE next cycle.
- io_out_valid  output  1  holding register holds an unread byte.
- io_out_ready  input  1  consumer accepts the byte when high together with valid.
- io_out_bits  output  8  received byte.
- io_err_frame  output  1  one-cycle pulse: stop bit sampled as 0.
- io_err_overrun  output  1  one-cycle pulse: a good byte was dropped because the holding register was full.
- io_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - Synchronizer flops and the prev-line flop reset to 1.
  - State IDLE; counters 0.
  - io_out_valid, io_out_bits, io_err_frame, io_err_overrun and io_busy all reset to 0.
- Synchronizer: `rxd_s` is io_rxd after SYNC_STAGES flops; `rxd_p` is `rxd_s` delayed one cycle.
- Divisor latch: io_div is captured into `div_q` when the start edge is detected and held for the whole frame. Changes to io_div mid-frame have no effect.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - A start edge (io_enable=1, rxd_p=1, rxd_s=0) loads `cnt = io_div>>1` and moves to START.
  - A line held low, such as a break, never retriggers because an edge is required.
- START:
  - `cnt` decrements each cycle.
  - When cnt=0, `rxd_s` is sampled. If 0: load `cnt=div_q`, `bitidx=0`, go to DATA. If 1: false start, return to IDLE with no error.
- DATA:
  - When cnt=0, shift `rxd_s` into shreg[7] with a right shift, so the first bit received lands at bit 0.
  - Reload `cnt=div_q`, `bitidx++`.
  - After the shift with bitidx=7, go to STOP.
- STOP: when cnt=0, sample `rxd_s`, then return to IDLE.
  - Sample = 1 (good byte), in priority order:
    - Register empty, or being dequeued this cycle (out_valid & out_ready): load io_out_bits=shreg and set io_out_valid=1 on the next edge.
    - Otherwise: drop the byte and pulse io_err_overrun; io_out_bits is unchanged.
  - Sample = 0: pulse io_err_frame; the byte is discarded and io_out_valid is unchanged.
- Timing:
  - Sample points, relative to the cycle T0 in which the start edge is seen on `rxd_s`:
    - start: T0+(div>>1)+1
    - data bit k: T0+(div>>1)+1+(k+1)(div+1)
    - stop: T0+(div>>1)+1+9(div+1)
  - io_out_valid rises one cycle after the stop sample.
- Handshake: on out_valid & out_ready, io_out_valid clears next cycle unless it is reloaded in the same cycle (simultaneous dequeue + load → valid stays 1 with the new byte).
- io_out_bits holds its value while valid=0.
- io_enable=0: any in-progress frame is abandoned with no error pulse. The holding register and its valid flag are unaffected.
- Asynchronous reset mid-frame aborts the frame and clears the holding register immediately.

Decomposition:
- Shared package n101_uart_pkg:
  - state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3), UART_DATA_BITS=8, UART_SYNC_DEFAULT=2.
  - The future TX engine reuses these.
- One sub-module: n101_sync_bit. It is a SYNC_STAGES-deep flop chain with an asynchronous reset value parameter (1 here).

Test Plan:
- div=15; send 0xA5 (bits 1,0,1,0,0,1,0,1, LSB first), out_ready=1 → io_out_valid pulses exactly at T0+153 with io_out_bits=0xA5; no error pulses.
- div=15; line low for 4 clocks then high → START aborts at T0+8; no valid, no error pulses; io_busy returns to 0.
- div=15; send 0x3C with the stop bit driven 0 → io_err_frame is a one-cycle pulse one cycle after the stop sample; io_out_valid stays 0. With the line then held low, no new frame starts.
- out_ready=0; send 0x11 then 0x22 back-to-back → io_out_bits=0x11 and valid are held; io_err_overrun pulses once after the second stop bit. Raising ready → 0x11 is dequeued, then valid=0.
- out_ready pulsed high exactly in the cycle the second byte's stop bit is sampled → valid stays 1, io_out_bits=0x22, no overrun.
- Assert reset during DATA bit 4 of 0xFF, then send 0x5A → no output from the aborted frame; 0x5A is received correctly. Changing io_div from 15 to 7 mid-frame does not alter the frame's timing.
